// File: rtl/lcd_scaler_pkg.sv
// Shared defaults and helpers for the LCD scaler: source geometry, frame-buffer
// address sizing and the power-on grey palette.
package lcd_scaler_pkg;

    localparam int SRC_W_DEFAULT = 160;
    localparam int SRC_H_DEFAULT = 144;

    // Window/active-video flags carried alongside the RAM read.
    typedef struct packed {
        logic win;
        logic de;
    } vid_ctl_t;

    // Two banks of w*h pixels; the bank select is the address MSB.
    function automatic int fb_addr_w(input int w, input int h);
        return $clog2(2 * w * h);
    endfunction

    // Entry 0 is white, the last entry is black, evenly spaced in between.
    function automatic logic [23:0] pal_reset_rgb(input int idx, input int pix_bits);
        int max_idx;
        int lvl;
        max_idx = (1 << pix_bits) - 1;
        lvl     = 255 - (idx * 255) / max_idx;
        return {3{lvl[7:0]}};
    endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port synchronous frame-buffer RAM: one write port, one read port,
// registered read data (1-cycle latency).
module lcd_fb_ram #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 2
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/lcd_scaler.sv
// Double-buffered scaler: captures a handheld LCD pixel stream into the back bank
// and displays the front bank, integer-scaled and palette-mapped, in a video window.
module lcd_scaler
    import lcd_scaler_pkg::*;
#(
    parameter int          SRC_W      = SRC_W_DEFAULT,
    parameter int          SRC_H      = SRC_H_DEFAULT,
    parameter int          PIX_BITS   = 2,
    parameter int          SCALE_LOG2 = 1,
    parameter int          X_OFF      = 160,
    parameter int          Y_OFF      = 76,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PIX_BITS-1:0] gb_pixel,
    input  logic                gb_latch,
    input  logic                gb_hsync,
    input  logic                gb_vsync,
    input  logic                pal_we,
    input  logic [PIX_BITS-1:0] pal_idx,
    input  logic [23:0]         pal_rgb,
    input  logic [10:0]         vid_x,
    input  logic [10:0]         vid_y,
    input  logic                vid_de,
    output logic [23:0]         rgb_out,
    output logic                de_out,
    output logic                front_bank,
    output logic                frame_dropped
);

    localparam int AW   = fb_addr_w(SRC_W, SRC_H);
    localparam int OW   = AW - 1;
    localparam int XW   = $clog2(SRC_W + 1);
    localparam int YW   = $clog2(SRC_H + 1);
    localparam int NPAL = 1 << PIX_BITS;

    localparam logic [11:0]   WIN_X0      = 12'(X_OFF);
    localparam logic [11:0]   WIN_X1      = 12'(X_OFF + (SRC_W << SCALE_LOG2));
    localparam logic [11:0]   WIN_Y0      = 12'(Y_OFF);
    localparam logic [11:0]   WIN_Y1      = 12'(Y_OFF + (SRC_H << SCALE_LOG2));
    localparam logic [XW-1:0] X_END       = XW'(SRC_W);
    localparam logic [YW-1:0] Y_END       = YW'(SRC_H);
    localparam logic [OW-1:0] LINE_STRIDE = OW'(SRC_W);

    logic          latch_q, hsync_q, vsync_q;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic          front_bank_q, front_bank_d;
    logic          swap_pending_q, swap_pending_d;
    logic          frame_dropped_q, frame_dropped_d;
    logic [23:0]   pal_q [NPAL];
    vid_ctl_t      ctl_s1_q;
    logic [23:0]   rgb_out_q;
    logic          de_out_q;

    logic          latch_rise, hsync_fall, vsync_rise;
    logic          wr_en;
    logic [OW-1:0] wr_off, rd_off;
    logic          in_win;
    logic [10:0]   x_rel, y_rel;
    logic [PIX_BITS-1:0] pix_rd;

    assign latch_rise = gb_latch & ~latch_q;
    assign hsync_fall = ~gb_hsync & hsync_q;
    assign vsync_rise = gb_vsync & ~vsync_q;

    // A vsync edge wins over a coincident latch edge: that pixel is dropped.
    assign wr_en  = latch_rise & ~vsync_rise & (wr_x_q < X_END) & (wr_y_q < Y_END);
    assign wr_off = OW'(wr_y_q) * LINE_STRIDE + OW'(wr_x_q);

    always_comb begin
        wr_x_d          = wr_x_q;
        wr_y_d          = wr_y_q;
        front_bank_d    = front_bank_q;
        swap_pending_d  = swap_pending_q;
        frame_dropped_d = 1'b0;
        if (swap_pending_q && vid_x == '0 && vid_y == '0) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
        end
        if (vsync_rise) begin
            wr_x_d = '0;
            wr_y_d = '0;
            if (wr_y_q == Y_END) begin
                swap_pending_d = 1'b1;
            end else begin
                frame_dropped_d = 1'b1;
            end
        end else if (hsync_fall) begin
            wr_x_d = '0;
            if (wr_y_q < Y_END) begin
                wr_y_d = wr_y_q + YW'(1);
            end
        end else if (latch_rise && wr_x_q < X_END) begin
            wr_x_d = wr_x_q + XW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q         <= 1'b0;
            hsync_q         <= 1'b0;
            vsync_q         <= 1'b0;
            wr_x_q          <= '0;
            wr_y_q          <= '0;
            front_bank_q    <= 1'b0;
            swap_pending_q  <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            latch_q         <= gb_latch;
            hsync_q         <= gb_hsync;
            vsync_q         <= gb_vsync;
            wr_x_q          <= wr_x_d;
            wr_y_q          <= wr_y_d;
            front_bank_q    <= front_bank_d;
            swap_pending_q  <= swap_pending_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    // Offsets are forced to zero outside the window so the subtraction never wraps into the RAM.
    assign in_win = ({1'b0, vid_x} >= WIN_X0) && ({1'b0, vid_x} < WIN_X1) &&
                    ({1'b0, vid_y} >= WIN_Y0) && ({1'b0, vid_y} < WIN_Y1);
    assign x_rel  = in_win ? (vid_x - 11'(X_OFF)) : '0;
    assign y_rel  = in_win ? (vid_y - 11'(Y_OFF)) : '0;
    assign rd_off = OW'(y_rel >> SCALE_LOG2) * LINE_STRIDE + OW'(x_rel >> SCALE_LOG2);

    lcd_fb_ram #(
        .ADDR_W (AW),
        .DATA_W (PIX_BITS)
    ) u_fb_ram (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i ({~front_bank_q, wr_off}),
        .wr_data_i (gb_pixel),
        .rd_addr_i ({front_bank_q, rd_off}),
        .rd_data_o (pix_rd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ctl_s1_q  <= '0;
            rgb_out_q <= BORDER_RGB;
            de_out_q  <= 1'b0;
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= pal_reset_rgb(i, PIX_BITS);
            end
        end else begin
            ctl_s1_q  <= '{win: in_win, de: vid_de};
            rgb_out_q <= ctl_s1_q.win ? pal_q[pix_rd] : BORDER_RGB;
            de_out_q  <= ctl_s1_q.de;
            if (pal_we) begin
                pal_q[pal_idx] <= pal_rgb;
            end
        end
    end

    assign rgb_out       = rgb_out_q;
    assign de_out        = de_out_q;
    assign front_bank    = front_bank_q;
    assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_lcd_scaler.sv
// Directed bench for lcd_scaler: frame capture, bank swap, scaled readout,
// palette, border, dropped frames, overflow and reset recovery.
module tb_lcd_scaler;

    localparam logic [23:0] BORDER = 24'h0A0B0C;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  gb_pixel = '0;
    logic        gb_latch = 1'b0;
    logic        gb_hsync = 1'b0;
    logic        gb_vsync = 1'b0;
    logic        pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [23:0] pal_rgb = '0;
    logic [10:0] vid_x = 11'd5;
    logic [10:0] vid_y = 11'd5;
    logic        vid_de = 1'b0;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        front_bank;
    logic        frame_dropped;

    int          vectors = 0;
    int          miscompares = 0;
    logic [24:0] exp_q[$];
    string       tag_q[$];
    logic [23:0] pal_m [4];

    always #5 clock = ~clock;

    lcd_scaler #(.BORDER_RGB(BORDER)) dut (
        .clock         (clock),
        .reset         (reset),
        .gb_pixel      (gb_pixel),
        .gb_latch      (gb_latch),
        .gb_hsync      (gb_hsync),
        .gb_vsync      (gb_vsync),
        .pal_we        (pal_we),
        .pal_idx       (pal_idx),
        .pal_rgb       (pal_rgb),
        .vid_x         (vid_x),
        .vid_y         (vid_y),
        .vid_de        (vid_de),
        .rgb_out       (rgb_out),
        .de_out        (de_out),
        .front_bank    (front_bank),
        .frame_dropped (frame_dropped)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired, %0d vectors applied", vectors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input int x, input int y);
        return x >= 160 && x < 480 && y >= 76 && y < 364;
    endfunction

    function automatic int pat_shade(input int x, input int y);
        return (((x - 160) / 2) + ((y - 76) / 2)) % 4;
    endfunction

    task automatic pop_check();
        logic [24:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_rgb"}, 32'(rgb_out), 32'(e[23:0]));
        check({t, "_de"}, 32'(de_out), 32'(e[24]));
    endtask

    task automatic vid_step(input string tag, input int x, input int y, input logic de, input int sh);
        logic [23:0] e;
        vid_x  = 11'(x);
        vid_y  = 11'(y);
        vid_de = de;
        e = in_win(x, y) ? pal_m[sh[1:0]] : BORDER;
        exp_q.push_back({de, e});
        tag_q.push_back(tag);
        tick();
        if (exp_q.size() == 2) pop_check();
    endtask

    task automatic vid_pat(input string tag, input int x, input int y, input logic de);
        vid_step(tag, x, y, de, in_win(x, y) ? pat_shade(x, y) : 0);
    endtask

    task automatic vid_flush();
        vid_x  = 11'd5;
        vid_y  = 11'd5;
        vid_de = 1'b0;
        while (exp_q.size() > 0) begin
            tick();
            pop_check();
        end
    endtask

    task automatic vid_origin();
        vid_x = '0;
        vid_y = '0;
        tick();
        vid_x = 11'd5;
        vid_y = 11'd5;
    endtask

    task automatic latch_pix(input int p);
        gb_pixel = 2'(p);
        gb_latch = 1'b1;
        tick();
        gb_latch = 1'b0;
        tick();
    endtask

    task automatic hsync_pulse();
        gb_hsync = 1'b1;
        tick();
        gb_hsync = 1'b0;
        tick();
    endtask

    task automatic pal_greys();
        pal_m[0] = 24'hFFFFFF;
        pal_m[1] = 24'hAAAAAA;
        pal_m[2] = 24'h555555;
        pal_m[3] = 24'h000000;
    endtask

    initial begin
        pal_greys();
        tick();
        tick();
        check("rst_rgb", 32'(rgb_out), 32'(BORDER));
        check("rst_de", 32'(de_out), 0);
        check("rst_front", 32'(front_bank), 0);
        check("rst_drop", 32'(frame_dropped), 0);
        check("rst_wrx", 32'(dut.wr_x_q), 0);
        check("rst_wry", 32'(dut.wr_y_q), 0);
        check("rst_pend", 32'(dut.swap_pending_q), 0);
        reset = 1'b0;
        tick();

        // Full frame of (x+y)%4 into bank 1.
        for (int y = 0; y < 144; y++) begin
            for (int x = 0; x < 160; x++) latch_pix((x + y) % 4);
            hsync_pulse();
        end
        check("ff_wry", 32'(dut.wr_y_q), 144);
        check("ff_wrx", 32'(dut.wr_x_q), 0);
        gb_vsync = 1'b1;
        tick();
        check("ff_pend", 32'(dut.swap_pending_q), 1);
        check("ff_nodrop", 32'(frame_dropped), 0);
        check("ff_front_hold", 32'(front_bank), 0);
        check("ff_wry_clr", 32'(dut.wr_y_q), 0);
        gb_vsync = 1'b0;
        tick();
        check("ff_front_wait", 32'(front_bank), 0);
        vid_origin();
        check("ff_swap", 32'(front_bank), 1);
        check("ff_pend_clr", 32'(dut.swap_pending_q), 0);

        vid_pat("px35_a", 166, 86, 1'b1);
        vid_pat("px35_b", 167, 86, 1'b1);
        vid_pat("px35_c", 166, 87, 1'b1);
        vid_pat("px35_d", 167, 87, 1'b1);
        vid_pat("px25", 165, 86, 1'b1);
        vid_pat("px45", 168, 86, 1'b1);
        vid_pat("origin", 160, 76, 1'b1);
        vid_pat("last_px", 478, 362, 1'b1);
        vid_pat("last_row", 162, 363, 1'b1);
        vid_pat("left_out", 159, 86, 1'b1);
        vid_pat("right_out", 480, 76, 1'b1);
        vid_pat("top_out", 160, 75, 1'b1);
        vid_pat("bot_out", 160, 364, 1'b1);
        vid_pat("border", 100, 50, 1'b1);
        vid_pat("border_de0", 100, 50, 1'b0);
        vid_flush();

        // Palette write: the read landing on the write edge still sees the old colour.
        vid_pat("pal_old", 164, 76, 1'b1);
        pal_m[2] = 24'hFF0000;
        pal_we   = 1'b1;
        pal_idx  = 2'd2;
        pal_rgb  = 24'hFF0000;
        vid_pat("pal_new", 164, 76, 1'b1);
        pal_we = 1'b0;
        vid_pat("pal_new2", 170, 78, 1'b1);
        vid_pat("pal_other", 166, 76, 1'b1);
        vid_flush();

        // Short frame of 100 lines is dropped.
        for (int i = 0; i < 100; i++) hsync_pulse();
        check("sf_wry", 32'(dut.wr_y_q), 100);
        gb_vsync = 1'b1;
        tick();
        check("sf_drop", 32'(frame_dropped), 1);
        check("sf_front", 32'(front_bank), 1);
        gb_vsync = 1'b0;
        tick();
        check("sf_drop_end", 32'(frame_dropped), 0);
        check("sf_wry_clr", 32'(dut.wr_y_q), 0);
        check("sf_pend", 32'(dut.swap_pending_q), 0);
        vid_origin();
        check("sf_front_after", 32'(front_bank), 1);

        // Overflowing line into bank 0: only 160 pixels are taken.
        for (int x = 0; x < 170; x++) latch_pix(x < 160 ? 2 : 3);
        check("ov_wrx_sat", 32'(dut.wr_x_q), 160);
        hsync_pulse();
        check("ov_wry", 32'(dut.wr_y_q), 1);
        check("ov_wrx_clr", 32'(dut.wr_x_q), 0);
        latch_pix(1);
        hsync_pulse();
        for (int i = 0; i < 142; i++) hsync_pulse();
        check("ov_wry_full", 32'(dut.wr_y_q), 144);
        gb_vsync = 1'b1;
        tick();
        check("ov_nodrop", 32'(frame_dropped), 0);
        gb_vsync = 1'b0;
        tick();
        vid_origin();
        check("ov_swap", 32'(front_bank), 0);
        vid_step("ov_px159", 478, 76, 1'b1, 2);
        vid_step("ov_px158", 477, 77, 1'b1, 2);
        vid_step("ov_next0", 160, 78, 1'b1, 1);
        vid_step("ov_next0b", 161, 79, 1'b1, 1);
        vid_flush();

        // Coincident vsync and latch edges.
        latch_pix(0);
        latch_pix(0);
        check("sim_pre_wrx", 32'(dut.wr_x_q), 2);
        gb_pixel = 2'd3;
        gb_vsync = 1'b1;
        gb_latch = 1'b1;
        tick();
        check("sim_drop", 32'(frame_dropped), 1);
        check("sim_wrx", 32'(dut.wr_x_q), 0);
        check("sim_wry", 32'(dut.wr_y_q), 0);
        gb_vsync = 1'b0;
        gb_latch = 1'b0;
        tick();
        check("sim_wrx_hold", 32'(dut.wr_x_q), 0);

        // Reset mid-line: counters clear, palette greys, frame buffer kept.
        latch_pix(1);
        latch_pix(1);
        latch_pix(1);
        check("rm_pre_wrx", 32'(dut.wr_x_q), 3);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pal_greys();
        check("rm_wrx", 32'(dut.wr_x_q), 0);
        check("rm_wry", 32'(dut.wr_y_q), 0);
        check("rm_front", 32'(front_bank), 0);
        check("rm_rgb", 32'(rgb_out), 32'(BORDER));
        check("rm_de", 32'(de_out), 0);
        vid_step("rm_grey2", 478, 76, 1'b1, 2);
        vid_step("rm_grey1", 160, 78, 1'b1, 1);
        vid_flush();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
